// File: rtl/vadd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vadd_pkg
//  Description : Shared definitions for the byte-serial vector add/sub lane:
//                element-width encodings, FSM state encodings, byte count
//                and element boundary helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package vadd_pkg;

   localparam int NUM_BYTES = 8;

   // Element width; the encoding doubles as log2(bytes per element).
   typedef enum logic [1:0] {
      SEW_8  = 2'b00,
      SEW_16 = 2'b01,
      SEW_32 = 2'b10,
      SEW_64 = 2'b11
   } sew_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Mask of the byte-within-element bits of a byte index.
   function automatic logic [2:0] elem_mask(input sew_e sew);
      logic [3:0] w_m;
      w_m = (4'd1 << sew) - 4'd1;
      return w_m[2:0];
   endfunction

   // Byte k is the least significant byte of its element.
   function automatic logic elem_lsb(input logic [2:0] k, input sew_e sew);
      return (k & elem_mask(sew)) == 3'd0;
   endfunction

   // Byte k is the most significant byte of its element.
   function automatic logic elem_msb(input logic [2:0] k, input sew_e sew);
      return (k & elem_mask(sew)) == elem_mask(sew);
   endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_byte.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_byte
//  Description : 8-bit full adder with carry-in, built as a Kogge-Stone
//                parallel-prefix carry network.
//  Ports       : a_i, b_i   - 8-bit operands
//                carry_i    - carry into bit 0
//                sum_o      - 8-bit sum
//                carry_o    - carry out of bit 7
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_byte (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       carry_i,
   output logic [7:0] sum_o,
   output logic       carry_o
);

   // Level 0 holds bitwise generate/propagate; levels 1..3 the prefix spans.
   logic [3:0][7:0] w_g;
   logic [3:0][7:0] w_p;
   logic [8:0]      w_c;

   // Carry-in folded into bit 0 generate so the prefix tree needs no extra column.
   assign w_p[0]    = a_i ^ b_i;
   assign w_g[0][0] = (a_i[0] & b_i[0]) | (w_p[0][0] & carry_i);
   assign w_g[0][7:1] = a_i[7:1] & b_i[7:1];

   generate
      for (genvar l = 1; l < 4; l++) begin : g_lvl
         localparam int D = 1 << (l - 1);
         for (genvar i = 0; i < 8; i++) begin : g_bit
            if (i >= D) begin : g_comb
               assign w_g[l][i] = w_g[l-1][i] | (w_p[l-1][i] & w_g[l-1][i-D]);
               assign w_p[l][i] = w_p[l-1][i] & w_p[l-1][i-D];
            end else begin : g_pass
               assign w_g[l][i] = w_g[l-1][i];
               assign w_p[l][i] = w_p[l-1][i];
            end
         end
      end
   endgenerate

   assign w_c[0]   = carry_i;
   assign w_c[8:1] = w_g[3];

   assign sum_o   = w_p[0] ^ w_c[7:0];
   assign carry_o = w_c[8];

endmodule
`default_nettype wire

// File: rtl/vadd_byte_serial_lane.sv
`default_nettype none
// ============================================================================
//  Module      : vadd_byte_serial_lane
//  Description : Byte-serial vector integer add/subtract lane. One 64-bit
//                operand pair is processed one byte per cycle through a
//                shared 8-bit adder; the carry chains within an element and
//                is reset (add) or forced (sub) at element boundaries.
//  Ports       : clk_i, rsn_i        - clock, synchronous active-low reset
//                valid_i / ready_o   - operand handshake
//                vs2_i, vs1_i        - operands (vd = vs2 +/- vs1)
//                sew_i, sub_i        - element width, subtract select
//                valid_o / ready_i   - result handshake
//                vd_o                - element-packed result
//                carry_out_o         - per-element carry (add) / borrow (sub)
//  Revision    : 1.0 - initial release
// ============================================================================
module vadd_byte_serial_lane
   import vadd_pkg::*;
(
   input  logic        clk_i,
   input  logic        rsn_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [63:0] vs2_i,
   input  logic [63:0] vs1_i,
   input  logic [1:0]  sew_i,
   input  logic        sub_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [63:0] vd_o,
   output logic [7:0]  carry_out_o
);

   state_e      r_state;
   logic [2:0]  r_k;
   logic [63:0] r_vs2;
   logic [63:0] r_vs1;
   sew_e        r_sew;
   logic        r_sub;
   logic        r_carry;
   logic [63:0] r_vd;
   logic [7:0]  r_co;
   logic        r_ready;
   logic        r_valid;

   logic [5:0]  w_base;
   logic [7:0]  w_a;
   logic [7:0]  w_b;
   logic        w_cin;
   logic [7:0]  w_sum;
   logic        w_cout;
   logic [2:0]  w_elem;

   assign w_base = {r_k, 3'b000};
   assign w_a    = r_vs2[w_base +: 8];
   // Subtract as vs2 + ~vs1 + 1: invert B, the +1 enters at each element LSB.
   assign w_b    = r_vs1[w_base +: 8] ^ {8{r_sub}};
   assign w_cin  = elem_lsb(r_k, r_sew) ? r_sub : r_carry;
   assign w_elem = r_k >> r_sew;

   full_adder_byte u_adder (
      .a_i     (w_a),
      .b_i     (w_b),
      .carry_i (w_cin),
      .sum_o   (w_sum),
      .carry_o (w_cout)
   );

   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         r_state <= ST_IDLE;
         r_k     <= 3'd0;
         r_vs2   <= 64'd0;
         r_vs1   <= 64'd0;
         r_sew   <= SEW_8;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_vd    <= 64'd0;
         r_co    <= 8'd0;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (valid_i && r_ready) begin
                  r_vs2   <= vs2_i;
                  r_vs1   <= vs1_i;
                  r_sew   <= sew_e'(sew_i);
                  r_sub   <= sub_i;
                  r_k     <= 3'd0;
                  r_carry <= 1'b0;
                  r_vd    <= 64'd0;
                  r_co    <= 8'd0;
                  r_ready <= 1'b0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_vd[w_base +: 8] <= w_sum;
               r_carry           <= w_cout;
               // Adder carry means "no borrow" when subtracting.
               if (elem_msb(r_k, r_sew))
                  r_co[w_elem] <= w_cout ^ r_sub;
               r_k <= r_k + 3'd1;
               if (r_k == 3'(NUM_BYTES - 1))
                  r_state <= ST_DONE;
            end
            ST_DONE: begin
               // First DONE cycle lets the last byte settle before valid is
               // raised; the handshake is only honoured once valid is visible.
               if (!r_valid) begin
                  r_valid <= 1'b1;
               end else if (ready_i) begin
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready_o     = r_ready;
   assign valid_o     = r_valid;
   assign vd_o        = r_vd;
   assign carry_out_o = r_co;

endmodule
`default_nettype wire

// File: tb/tb_vadd_byte_serial_lane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vadd_byte_serial_lane
//  Description : Self-checking bench for vadd_byte_serial_lane with an
//                element-level arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vadd_byte_serial_lane;

   logic        clk = 1'b0;
   logic        rsn;
   logic        valid_i;
   logic        ready_o;
   logic [63:0] vs2;
   logic [63:0] vs1;
   logic [1:0]  sew;
   logic        sub;
   logic        valid_o;
   logic        ready_i;
   logic [63:0] vd;
   logic [7:0]  co;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   vadd_byte_serial_lane dut (
      .clk_i       (clk),
      .rsn_i       (rsn),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .vs2_i       (vs2),
      .vs1_i       (vs1),
      .sew_i       (sew),
      .sub_i       (sub),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .vd_o        (vd),
      .carry_out_o (co)
   );

   // Element-wise arithmetic: modulo 2^w result plus carry-out / borrow.
   function automatic void ref_model(input logic [63:0] a, input logic [63:0] b,
                                     input logic [1:0] s, input logic is_sub,
                                     output logic [63:0] r_vd, output logic [7:0] r_co);
      int w;
      int ne;
      logic [64:0] mask;
      logic [64:0] ea;
      logic [64:0] eb;
      logic [64:0] res;
      w  = 8 << s;
      ne = 8 >> s;
      mask = (65'd1 << w) - 65'd1;
      r_vd = 64'd0;
      r_co = 8'd0;
      for (int e = 0; e < ne; e++) begin
         ea = ({1'b0, a} >> (e * w)) & mask;
         eb = ({1'b0, b} >> (e * w)) & mask;
         if (is_sub) begin
            res     = (ea - eb) & mask;
            r_co[e] = (ea < eb);
         end else begin
            res     = ea + eb;
            r_co[e] = res[w];
            res     = res & mask;
         end
         r_vd = r_vd | (res[63:0] << (e * w));
      end
   endfunction

   function automatic logic [63:0] rand_operand();
      case ($urandom_range(0, 4))
         0:       return 64'hFFFF_FFFF_FFFF_FFFF;
         1:       return 64'd0;
         2:       return {8{8'h80}};
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   // Issue one operand pair at the next opportunity; leaves time just after the accept edge.
   task automatic accept_op(input logic [63:0] a, input logic [63:0] b,
                            input logic [1:0] s, input logic is_sub, output bit ok);
      int t = 0;
      @(negedge clk);
      while (!ready_o && t < 40) begin
         @(negedge clk);
         t++;
      end
      ok = ready_o;
      if (!ok) begin
         n_checks++;
         $display("FAIL accept_timeout: ready_o=%0b required 1", ready_o);
         return;
      end
      vs2 = a; vs1 = b; sew = s; sub = is_sub; valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      vs2 = {$urandom(), $urandom()};
      vs1 = {$urandom(), $urandom()};
      sew = 2'($urandom());
      sub = 1'($urandom());
   endtask

   // Accept, wait for the result, capture it, then hand it off.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] s, input logic is_sub,
                         output logic [63:0] got_vd, output logic [7:0] got_co, output bit ok);
      int lat = 0;
      accept_op(a, b, s, is_sub, ok);
      if (!ok) return;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (valid_o) break;
      end
      ok = valid_o;
      got_vd = vd;
      got_co = co;
      if (!ok) begin
         n_checks++;
         $display("FAIL result_timeout: valid_o=%0b required 1", valid_o);
         return;
      end
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rsn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({ready_o, valid_o} !== 2'b10 || vd !== 64'd0 || co !== 8'd0)
         $display("FAIL reset_state: ready=%0b valid=%0b vd=%h co=%h required 1 0 0 0",
                  ready_o, valid_o, vd, co);
      else n_pass++;
      rsn = 1'b1;
   endtask

   task automatic test_directed();
      logic [63:0] gv; logic [7:0] gc; bit ok;
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 2'b00, 1'b0, gv, gc, ok);
      n_checks++;
      if (gv !== 64'd0 || gc !== 8'hFF)
         $display("FAIL dir_sew8_add: vd=%h co=%h required 0 ff", gv, gc);
      else n_pass++;
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b11, 1'b0, gv, gc, ok);
      n_checks++;
      if (gv !== 64'd0 || gc !== 8'h01)
         $display("FAIL dir_sew64_add: vd=%h co=%h required 0 01", gv, gc);
      else n_pass++;
      run_op(64'h0000_0001_0005_0003, 64'h0001_0001_0003_0004, 2'b01, 1'b1, gv, gc, ok);
      n_checks++;
      if (gv !== 64'hFFFF_0000_0002_FFFF || gc !== 8'h09)
         $display("FAIL dir_sew16_sub: vd=%h co=%h required ffff00000002ffff 09", gv, gc);
      else n_pass++;
   endtask

   task automatic test_random(input int n);
      logic [63:0] a, b, gv, ev; logic [7:0] gc, ec; logic [1:0] s; logic su; bit ok;
      for (int i = 0; i < n; i++) begin
         a = rand_operand(); b = rand_operand();
         s = 2'($urandom()); su = 1'($urandom());
         ref_model(a, b, s, su, ev, ec);
         run_op(a, b, s, su, gv, gc, ok);
         if (ok) begin
            n_checks++;
            if (gv !== ev || gc !== ec)
               $display("FAIL rand_%0d sew=%0d sub=%0b: vd=%h co=%h required %h %h",
                        i, s, su, gv, gc, ev, ec);
            else n_pass++;
         end
      end
   endtask

   task automatic test_latency_backpressure();
      logic [63:0] a, b, ev; logic [7:0] ec; bit ok;
      int first_valid = 0;
      int ready_hi = 0;
      bit held = 1'b1;
      a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
      ref_model(a, b, 2'b10, 1'b0, ev, ec);
      accept_op(a, b, 2'b10, 1'b0, ok);
      for (int e = 1; e <= 9; e++) begin
         @(posedge clk);
         #1;
         if (ready_o) ready_hi++;
         if (valid_o && first_valid == 0) first_valid = e;
      end
      n_checks++;
      if (first_valid != 9)
         $display("FAIL latency: first valid edge=%0d required 9", first_valid);
      else n_pass++;
      n_checks++;
      if (ready_hi != 0)
         $display("FAIL ready_busy: ready_o high on %0d edges required 0", ready_hi);
      else n_pass++;
      // Hold off the consumer while offering a new operand pair.
      for (int c = 0; c < 5; c++) begin
         valid_i = (c == 2);
         vs2 = {$urandom(), $urandom()};
         @(posedge clk);
         #1;
         if (!valid_o || ready_o || vd !== ev || co !== ec) held = 1'b0;
      end
      valid_i = 1'b0;
      n_checks++;
      if (!held)
         $display("FAIL backpressure_hold: valid=%0b ready=%0b vd=%h co=%h required 1 0 %h %h",
                  valid_o, ready_o, vd, co, ev, ec);
      else n_pass++;
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      ready_i = 1'b0;
      n_checks++;
      if ({valid_o, ready_o} !== 2'b01)
         $display("FAIL backpressure_release: valid=%0b ready=%0b required 0 1", valid_o, ready_o);
      else n_pass++;
   endtask

   task automatic test_mid_run_reset();
      logic [63:0] gv, ev; logic [7:0] gc, ec; bit ok;
      accept_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 2'b00, 1'b0, ok);
      repeat (3) @(posedge clk);
      #1;
      rsn = 1'b0;
      @(posedge clk);
      #1;
      rsn = 1'b1;
      n_checks++;
      if ({ready_o, valid_o} !== 2'b10 || vd !== 64'd0 || co !== 8'd0)
         $display("FAIL midrun_reset: ready=%0b valid=%0b vd=%h co=%h required 1 0 0 0",
                  ready_o, valid_o, vd, co);
      else n_pass++;
      ref_model(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 2'b00, 1'b0, ev, ec);
      run_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 2'b00, 1'b0, gv, gc, ok);
      n_checks++;
      if (gv[7:0] !== 8'h02 || gv !== ev || gc !== ec)
         $display("FAIL post_reset_add: vd=%h co=%h required %h %h", gv, gc, ev, ec);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] a, b, gv, ev; logic [7:0] gc, ec; logic [1:0] s; bit ok;
      for (int i = 0; i < 6; i++) begin
         a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
         s = 2'(i % 4);
         ref_model(a, b, s, 1'b1, ev, ec);
         run_op(a, b, s, 1'b1, gv, gc, ok);
         if (ok) begin
            n_checks++;
            if (gv !== ev || gc !== ec)
               $display("FAIL b2b_%0d sew=%0d: vd=%h co=%h required %h %h", i, s, gv, gc, ev, ec);
            else n_pass++;
         end
      end
   endtask

   initial begin
      rsn = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
      vs2 = 64'd0; vs1 = 64'd0; sew = 2'b00; sub = 1'b0;
      test_reset();
      test_directed();
      test_latency_backpressure();
      test_mid_run_reset();
      test_random(40);
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
